// File: rtl/writeback_arbiter.sv
// writeback_arbiter: owns the regfile write port. Chooses each cycle between
// the pipeline writeback and buffered multdiv results, tracks registers still
// waiting on a multdiv result, and drives registered regfile write controls.
module writeback_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_hold,
  input  logic        md_start,
  input  logic [4:0]  md_rd,
  output logic        md_ready,
  input  logic        md_resultRDY,
  input  logic [31:0] md_result,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  input  logic [4:0]  chk_rd,
  output logic        stall_hazard,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  // State
  logic        inflight_q, inflight_d;
  logic [4:0]  inflight_rd_q, inflight_rd_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] pending_q, pending_d;
  logic [2:0]  starve_q, starve_d;
  logic        we_q, we_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;

  // FIFO storage (contents need no reset; count qualifies them)
  logic [4:0]  fifo_rd_q   [2];
  logic [31:0] fifo_data_q [2];

  // Per-cycle decisions
  logic        issue;
  logic        push;
  logic        pop;
  logic        force_drain;
  logic        wb_ok;
  logic        sel_pipe;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  // Arbitration, scoreboard and next-state computation
  always_comb begin
    head_rd     = fifo_rd_q[rd_ptr_q];
    head_data   = fifo_data_q[rd_ptr_q];

    md_ready    = !inflight_q && (count_q < 2'd2) &&
                  ((md_rd == 5'd0) || !pending_q[md_rd]);
    issue       = md_start && md_ready;
    push        = md_resultRDY && inflight_q;

    force_drain = (count_q != 2'd0) && (starve_q == STARVE_MAX);
    wb_ok       = wb_valid && (wb_rd != 5'd0);
    sel_pipe    = !force_drain && wb_ok;
    pop         = !sel_pipe && (count_q != 2'd0);
    // A held pipeline write only happens when a forced drain beats it.
    wb_hold     = force_drain && wb_ok;

    inflight_d    = inflight_q;
    inflight_rd_d = inflight_rd_q;
    if (push) begin
      inflight_d = 1'b0;
    end
    if (issue) begin
      inflight_d    = 1'b1;
      inflight_rd_d = md_rd;
    end

    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // The popped rd is always pending (unless r0), and issue requires md_rd
    // not pending, so the clear and set below never target the same bit.
    pending_d = pending_q;
    if (pop && (head_rd != 5'd0)) begin
      pending_d[head_rd] = 1'b0;
    end
    if (issue && (md_rd != 5'd0)) begin
      pending_d[md_rd] = 1'b1;
    end

    starve_d = starve_q;
    if (pop || (count_q == 2'd0)) begin
      starve_d = 3'd0;
    end else if (sel_pipe && (starve_q < STARVE_MAX)) begin
      starve_d = starve_q + 3'd1;
    end

    we_d    = 1'b0;
    wreg_d  = 5'd0;
    wdata_d = 32'd0;
    if (sel_pipe) begin
      we_d    = 1'b1;
      wreg_d  = wb_rd;
      wdata_d = wb_data;
    end else if (pop && (head_rd != 5'd0)) begin
      we_d    = 1'b1;
      wreg_d  = head_rd;
      wdata_d = head_data;
    end
  end

  // Hazard check for the instruction in decode (RAW and WAW)
  always_comb begin
    stall_hazard = ((chk_rs1 != 5'd0) && pending_q[chk_rs1]) ||
                   ((chk_rs2 != 5'd0) && pending_q[chk_rs2]) ||
                   ((chk_rd  != 5'd0) && pending_q[chk_rd]);
  end

  // Control state registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight_q    <= 1'b0;
      inflight_rd_q <= 5'd0;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      pending_q     <= 32'd0;
      starve_q      <= 3'd0;
      we_q          <= 1'b0;
      wreg_q        <= 5'd0;
      wdata_q       <= 32'd0;
    end else begin
      inflight_q    <= inflight_d;
      inflight_rd_q <= inflight_rd_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      pending_q     <= pending_d;
      starve_q      <= starve_d;
      we_q          <= we_d;
      wreg_q        <= wreg_d;
      wdata_q       <= wdata_d;
    end
  end

  // FIFO storage write on a multdiv result push
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= inflight_rd_q;
      fifo_data_q[wr_ptr_q] <= md_result;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;

endmodule
